pattern_sequencer: RTL and testbench
====================================

# pattern_sequencer

Parametrised successor to the fixed three-pattern selector. It sequences `NUM_PATTERNS` pattern generators with a per-pattern frame duration. It adds a runtime skip mask, manual next/previous requests and a hold mode. All pattern changes are deferred to the vsync rising edge, so every frame is drawn by a single generator. It sits between the VGA timing core and the pattern generators: it drives their enable and next-frame strobes and muxes their `RGB_W` colour outputs.

## Interface
- `NUM_PATTERNS`, default 4 — number of generators; range 2..16.
- `SEL_W`, default 2 — select width; must satisfy 2^SEL_W ≥ NUM_PATTERNS.
- `CNT_W`, default 10 — frame counter width.
- `RGB_W`, default 6 — colour width per generator.
- `FRAME_LIST`, default {10'd300,10'd360,10'd480,10'd240} — packed durations in frames.
  - Pattern i occupies `[i*CNT_W +: CNT_W]`.
  - A duration of 0 means hold indefinitely.

Ports:
- `clk`  in  1 — pixel clock.
- `rst_n`  in  1 — asynchronous, active-low reset.
- `vsync`  in  1 — VGA vsync, active low. A frame starts at its rising edge.
- `paused`  in  1 — freezes animation strobes and the frame counter.
- `hold`  in  1 — 1 = manual mode: no auto-advance; requests still honoured.
- `next_req`  in  1 — single-cycle request to step forward.
- `prev_req`  in  1 — single-cycle request to step backward.
- `skip_mask`  in  NUM_PATTERNS — bit i = 1 excludes pattern i from selection.
- `pattern_rgb`  in  NUM_PATTERNS*RGB_W — generator outputs; pattern i at `[i*RGB_W +: RGB_W]`.
- `pattern_sel`  out  SEL_W — current pattern index (registered).
- `pattern_en`  out  NUM_PATTERNS — one-hot of `pattern_sel`.
- `frame_tick`  out  NUM_PATTERNS — per-generator next-frame strobe.
- `frame_count`  out  CNT_W — frames elapsed in the current pattern (registered).
- `switched`  out  1 — one-cycle pulse in the cycle after `pattern_sel` changes.
- `rgb`  out  RGB_W — selected generator colour.

## Operation
- **Edge detect:** `vsync_q` resets to 1. `vs_rise = vsync & ~vsync_q`.
- **Request latching:** `next_req` and `prev_req` set `pend_next` and `pend_prev`, held until the next `vs_rise`.
  - A request arriving in the same cycle as `vs_rise` is included in that edge's decision.
  - If both are pending at the edge, both are cancelled and no switch occurs.
- **Successor search:** the next index is found cyclically from `pattern_sel`, forward for next and backward for prev, taking the first index with `skip_mask = 0`.
  - The search excludes the current index.
  - If no other index is unmasked, `pattern_sel` is unchanged, `frame_count` still clears, and `switched` stays low.
- **Decision on each `vs_rise`, in priority order:**
  1. A pending request (next or prev alone) → move to the successor; `frame_count` ← 0; clear pending.
  2. Otherwise, when `paused = 0`, `hold = 0`, D = FRAME_LIST[sel] ≠ 0 and `frame_count == D-1` → forward successor; `frame_count` ← 0.
  3. Otherwise, when `paused = 0` and `hold = 0` → `frame_count` + 1, saturating at all-ones.
  4. When `paused = 1` or `hold = 1` → `frame_count` unchanged.
- **Masked current pattern:** if the current pattern becomes masked, it keeps displaying until the next switch event.
- **Enables and strobes:**
  - `pattern_en` = one-hot(`pattern_sel`).
  - `frame_tick[i] = vs_rise & ~paused & (pattern_sel == i)`.
  - Generators therefore receive the strobe based on the pre-switch select.
- **Colour mux:** `rgb` = `pattern_rgb[pattern_sel]`. If `pattern_sel ≥ NUM_PATTERNS`, `rgb` = 0.

## Timing
- **Reset values (`rst_n` low, asynchronous):**
  - `pattern_sel` = 0, `frame_count` = 0, `switched` = 0.
  - Pending flags cleared, `vsync_q` = 1.
  - `pattern_en` = 1, `frame_tick` = 0, `rgb` = `pattern_rgb[0 +: RGB_W]`.
  - Deassertion mid-frame: the first `vs_rise` is detected no earlier than the cycle after deassertion. A high `vsync` at deassertion never produces a spurious edge.
- **Latencies:**
  - `pattern_sel` and `frame_count` update one clock after the `vs_rise` cycle.
  - `switched` asserts one clock after that.
  - `frame_tick` is combinational in the `vs_rise` cycle.
  - `rgb` and `pattern_en` are combinational from registered `pattern_sel`, so they are valid for the entire frame that follows.
- **Runtime inputs:** `skip_mask` and `hold` are sampled only in `vs_rise` cycles.

## Test plan
- **Auto sequence:** defaults; 240 `vs_rise` → `pattern_sel` 0→1 after the 240th edge, `switched` for 1 cycle. A further 480 edges → 2, 360 → 3, 300 → 0.
- **Pause:** `paused = 1` over 100 edges at `frame_count` = 50 → `frame_count` stays 50, `frame_tick` = 0. Release: the switch occurs after 190 more edges.
- **Requests and hold:** `hold = 1`, `next_req` pulse mid-frame → switch at the next edge, `frame_count` = 0. `prev_req` → back to the original pattern. `next_req` and `prev_req` in the same frame → no change.
- **Skip mask:** `skip_mask` = 4'b0110 at sel 0 → next goes to 3, prev from 3 goes to 0. `skip_mask` = 4'b1110 → `pattern_sel` stays 0, no `switched`.
- **Zero duration:** FRAME_LIST entry 1 = 0 → pattern 1 holds over 2000 edges; `frame_count` saturates at 1023.
- **Async reset:** assert `rst_n` low mid-frame with pattern 2 active → all outputs at reset values immediately, without a clock edge. Deassert with `vsync` high → no switch until a real rising edge.

Source files
------------

// File: rtl/pattern_sequencer.sv
// pattern_sequencer: steps through NUM_PATTERNS generators with per-pattern
// frame durations. It supports a skip mask, manual next/prev requests and a
// hold mode. Every select change lands on a vsync rising edge, so one
// generator draws each whole frame.

// Per-generator slice: enable, next-frame strobe and gated colour contribution.
module pattern_sequencer_lane #(
    parameter int SEL_W = 2,
    parameter int RGB_W = 6,
    parameter int IDX   = 0
) (
    input  logic [SEL_W-1:0] sel,
    input  logic             vs_rise,
    input  logic             paused,
    input  logic [RGB_W-1:0] rgb_in,
    output logic             en,
    output logic             tick,
    output logic [RGB_W-1:0] rgb_out
);
    assign en      = (sel == SEL_W'(IDX));
    // The strobe uses the select that was active during the frame just ending.
    assign tick    = vs_rise & ~paused & en;
    assign rgb_out = rgb_in & {RGB_W{en}};
endmodule

module pattern_sequencer #(
    parameter int NUM_PATTERNS = 4,
    parameter int SEL_W        = 2,
    parameter int CNT_W        = 10,
    parameter int RGB_W        = 6,
    parameter logic [NUM_PATTERNS*CNT_W-1:0] FRAME_LIST =
        {10'd300, 10'd360, 10'd480, 10'd240}
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          vsync,
    input  logic                          paused,
    input  logic                          hold,
    input  logic                          next_req,
    input  logic                          prev_req,
    input  logic [NUM_PATTERNS-1:0]       skip_mask,
    input  logic [NUM_PATTERNS*RGB_W-1:0] pattern_rgb,
    output logic [SEL_W-1:0]              pattern_sel,
    output logic [NUM_PATTERNS-1:0]       pattern_en,
    output logic [NUM_PATTERNS-1:0]       frame_tick,
    output logic [CNT_W-1:0]              frame_count,
    output logic                          switched,
    output logic [RGB_W-1:0]              rgb
);

    logic                                  vsync_q;
    logic                                  vs_rise;
    logic                                  pend_next;
    logic                                  pend_prev;
    logic                                  req_next;
    logic                                  req_prev;
    logic [SEL_W-1:0]                      sel_d;
    logic [SEL_W-1:0]                      sel_nxt;
    logic [CNT_W-1:0]                      cnt_nxt;
    logic [CNT_W-1:0]                      dur;
    logic [SEL_W-1:0]                      succ_fwd;
    logic [SEL_W-1:0]                      succ_bwd;
    logic [NUM_PATTERNS-1:0][RGB_W-1:0]    lane_rgb;

    assign vs_rise  = vsync & ~vsync_q;
    // A request landing in the edge cycle itself still counts for that edge.
    assign req_next = pend_next | next_req;
    assign req_prev = pend_prev | prev_req;

    // First unmasked index cyclically away from cur, never cur itself;
    // returns cur when every other index is masked.
    function automatic logic [SEL_W-1:0] successor(
        input logic [SEL_W-1:0]        cur,
        input logic [NUM_PATTERNS-1:0] mask,
        input logic                    fwd
    );
        logic [SEL_W-1:0] res;
        logic [SEL_W-1:0] cand;
        logic             found;
        int               idx;
        res   = cur;
        found = 1'b0;
        for (int k = 1; k < NUM_PATTERNS; k++) begin
            if (fwd) idx = (int'(cur) + k) % NUM_PATTERNS;
            else     idx = (int'(cur) + NUM_PATTERNS - k) % NUM_PATTERNS;
            cand = SEL_W'(idx);
            if (!found && !mask[cand]) begin
                res   = cand;
                found = 1'b1;
            end
        end
        return res;
    endfunction

    // Duration of the currently selected pattern.
    always_comb begin
        dur = '0;
        for (int i = 0; i < NUM_PATTERNS; i++) begin
            if (pattern_sel == SEL_W'(i)) dur = FRAME_LIST[i*CNT_W +: CNT_W];
        end
    end

    assign succ_fwd = successor(pattern_sel, skip_mask, 1'b1);
    assign succ_bwd = successor(pattern_sel, skip_mask, 1'b0);

    // Frame-edge decision: lone request, then auto-advance, then counting.
    // Opposing requests cancel each other and the edge is treated as if no
    // request had been made.
    always_comb begin
        sel_nxt = pattern_sel;
        cnt_nxt = frame_count;
        if (vs_rise) begin
            if (req_next ^ req_prev) begin
                sel_nxt = req_next ? succ_fwd : succ_bwd;
                cnt_nxt = '0;
            end else if (!paused && !hold && dur != '0 &&
                         frame_count == dur - CNT_W'(1)) begin
                sel_nxt = succ_fwd;
                cnt_nxt = '0;
            end else if (!paused && !hold && frame_count != '1) begin
                cnt_nxt = frame_count + CNT_W'(1);
            end
        end
    end

    // vsync edge history; reset high so a high vsync at release is not an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vsync_q <= 1'b1;
        else        vsync_q <= vsync;
    end

    // Pending requests live until the next frame edge consumes them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_next <= 1'b0;
            pend_prev <= 1'b0;
        end else if (vs_rise) begin
            pend_next <= 1'b0;
            pend_prev <= 1'b0;
        end else begin
            if (next_req) pend_next <= 1'b1;
            if (prev_req) pend_prev <= 1'b1;
        end
    end

    // Select and frame counter state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pattern_sel <= '0;
            frame_count <= '0;
        end else begin
            pattern_sel <= sel_nxt;
            frame_count <= cnt_nxt;
        end
    end

    // switched pulses one cycle after the select register has changed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_d    <= '0;
            switched <= 1'b0;
        end else begin
            sel_d    <= pattern_sel;
            switched <= (pattern_sel != sel_d);
        end
    end

    for (genvar i = 0; i < NUM_PATTERNS; i++) begin : g_lane
        pattern_sequencer_lane #(
            .SEL_W (SEL_W),
            .RGB_W (RGB_W),
            .IDX   (i)
        ) u_lane (
            .sel     (pattern_sel),
            .vs_rise (vs_rise),
            .paused  (paused),
            .rgb_in  (pattern_rgb[i*RGB_W +: RGB_W]),
            .en      (pattern_en[i]),
            .tick    (frame_tick[i]),
            .rgb_out (lane_rgb[i])
        );
    end

    // Lanes are gated by their enable, so OR-ing them is the mux; an
    // out-of-range select enables no lane and yields zero.
    always_comb begin
        rgb = '0;
        for (int i = 0; i < NUM_PATTERNS; i++) rgb = rgb | lane_rgb[i];
    end

endmodule

// File: tb/tb_pattern_sequencer.sv
// Bench for pattern_sequencer: directed phases plus randomized frames, all
// checked against a frame-level reference model of the sequencing rules.
module tb_pattern_sequencer;

    localparam int N   = 4;
    localparam int RW  = 6;
    localparam int CW  = 10;
    localparam int SAT = 1023;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            vsync, paused, hold, next_req, prev_req;
    logic [N-1:0]    skip_mask;
    logic [N*RW-1:0] pattern_rgb;

    logic [1:0]      pattern_sel, z_sel;
    logic [N-1:0]    pattern_en, z_en, frame_tick, z_tick;
    logic [CW-1:0]   frame_count, z_fc;
    logic            switched, z_sw;
    logic [RW-1:0]   rgb, z_rgb;

    int checks = 0;
    int errors = 0;

    // reference model state
    int   dur[N] = '{240, 480, 360, 300};
    int   m_sel, m_fc, m_tick;
    logic m_pn, m_pp, m_sw;

    always #5 clk = ~clk;

    pattern_sequencer dut (
        .clk(clk), .rst_n(rst_n), .vsync(vsync), .paused(paused), .hold(hold),
        .next_req(next_req), .prev_req(prev_req), .skip_mask(skip_mask),
        .pattern_rgb(pattern_rgb), .pattern_sel(pattern_sel),
        .pattern_en(pattern_en), .frame_tick(frame_tick),
        .frame_count(frame_count), .switched(switched), .rgb(rgb)
    );

    // second instance: pattern 1 has duration 0 (hold indefinitely)
    pattern_sequencer #(
        .FRAME_LIST({10'd300, 10'd360, 10'd0, 10'd240})
    ) dut_z (
        .clk(clk), .rst_n(rst_n), .vsync(vsync), .paused(paused), .hold(hold),
        .next_req(next_req), .prev_req(prev_req), .skip_mask(skip_mask),
        .pattern_rgb(pattern_rgb), .pattern_sel(z_sel),
        .pattern_en(z_en), .frame_tick(z_tick),
        .frame_count(z_fc), .switched(z_sw), .rgb(z_rgb)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    function automatic int find_next(input int cur, input logic fwd);
        for (int k = 1; k < N; k++) begin
            int c;
            c = fwd ? (cur + k) % N : (cur + N - k) % N;
            if (!skip_mask[c]) return c;
        end
        return cur;
    endfunction

    function automatic int exp_rgb(input int sel);
        logic [N*RW-1:0] t;
        t = pattern_rgb >> (sel * RW);
        return int'(t[RW-1:0]);
    endfunction

    task automatic model_reset();
        m_sel = 0; m_fc = 0; m_pn = 0; m_pp = 0; m_sw = 0; m_tick = 0;
    endtask

    // one frame edge, using the input values present in the edge cycle
    task automatic model_edge(input logic en_n, input logic en_p);
        logic rn, rp;
        int   old;
        rn     = m_pn | en_n;
        rp     = m_pp | en_p;
        old    = m_sel;
        m_tick = paused ? 0 : (1 << m_sel);
        if (rn != rp) begin
            m_sel = find_next(m_sel, rn);
            m_fc  = 0;
        end else if (!paused && !hold && dur[m_sel] != 0 && m_fc == dur[m_sel] - 1) begin
            m_sel = find_next(m_sel, 1'b1);
            m_fc  = 0;
        end else if (!paused && !hold && m_fc < SAT) begin
            m_fc++;
        end
        m_pn = 0;
        m_pp = 0;
        m_sw = (m_sel != old);
    endtask

    // One 5-cycle frame: mid = request pulse while vsync low,
    // erq = request issued in the vs_rise cycle itself. Bit0 next, bit1 prev.
    task automatic do_frame(input logic [1:0] mid, input logic [1:0] erq);
        @(posedge clk); #1;
        vsync = 1'b0; next_req = mid[0]; prev_req = mid[1];
        pattern_rgb = (N*RW)'($urandom);
        m_pn = m_pn | mid[0];
        m_pp = m_pp | mid[1];
        #1;
        check("sw_low", 32'(switched), 0);
        check("tick_idle", 32'(frame_tick), 0);
        @(posedge clk); #1;
        next_req = 1'b0; prev_req = 1'b0;
        @(posedge clk); #1;
        vsync = 1'b1; next_req = erq[0]; prev_req = erq[1];
        model_edge(erq[0], erq[1]);
        #1;
        check("tick", 32'(frame_tick), 32'(m_tick));
        @(posedge clk); #1;
        next_req = 1'b0; prev_req = 1'b0;
        #1;
        check("sel", 32'(pattern_sel), 32'(m_sel));
        check("fc", 32'(frame_count), 32'(m_fc));
        check("en", 32'(pattern_en), 32'(1 << m_sel));
        check("rgb", 32'(rgb), 32'(exp_rgb(m_sel)));
        @(posedge clk); #1;
        check("switched", 32'(switched), 32'(m_sw));
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) do_frame(2'b00, 2'b00);
    endtask

    initial begin
        rst_n = 1'b0; vsync = 1'b1; paused = 1'b0; hold = 1'b0;
        next_req = 1'b0; prev_req = 1'b0; skip_mask = '0;
        pattern_rgb = 24'hABCDEF;
        model_reset();
        #12;
        // reset state
        check("rst_sel", 32'(pattern_sel), 0);
        check("rst_fc", 32'(frame_count), 0);
        check("rst_sw", 32'(switched), 0);
        check("rst_en", 32'(pattern_en), 1);
        check("rst_tick", 32'(frame_tick), 0);
        check("rst_rgb", 32'(rgb), 32'(pattern_rgb[RW-1:0]));
        @(posedge clk); #1;
        rst_n = 1'b1;

        // auto sequence
        frames(239);
        check("auto_239_sel", 32'(pattern_sel), 0);
        check("auto_239_fc", 32'(frame_count), 239);
        frames(1);
        check("auto_240_sel", 32'(pattern_sel), 1);
        frames(480);
        check("auto_p2", 32'(pattern_sel), 2);
        check("zero_sel", 32'(z_sel), 1);
        check("zero_cnt", 32'(z_fc), 480);
        frames(360);
        check("auto_p3", 32'(pattern_sel), 3);
        frames(300);
        check("auto_wrap", 32'(pattern_sel), 0);
        check("auto_wrap_fc", 32'(frame_count), 0);
        check("zero_hold_sel", 32'(z_sel), 1);
        check("zero_sat", 32'(z_fc), SAT);

        // pause
        frames(50);
        paused = 1'b1;
        frames(100);
        check("pause_fc", 32'(frame_count), 50);
        paused = 1'b0;
        frames(189);
        check("pause_rel_sel", 32'(pattern_sel), 0);
        frames(1);
        check("pause_rel_sw", 32'(pattern_sel), 1);
        check("zero_sat2", 32'(z_fc), SAT);

        // requests and hold (currently at 1)
        hold = 1'b1;
        frames(3);
        do_frame(2'b01, 2'b00);
        check("req_next", 32'(pattern_sel), 2);
        check("req_next_fc", 32'(frame_count), 0);
        do_frame(2'b10, 2'b00);
        check("req_prev", 32'(pattern_sel), 1);
        do_frame(2'b11, 2'b00);
        check("req_both", 32'(pattern_sel), 1);
        do_frame(2'b00, 2'b01);
        check("req_edge_next", 32'(pattern_sel), 2);
        do_frame(2'b01, 2'b10);
        check("req_mixed", 32'(pattern_sel), 2);
        do_frame(2'b00, 2'b10);
        do_frame(2'b10, 2'b00);
        check("req_to0", 32'(pattern_sel), 0);

        // skip mask
        skip_mask = 4'b0110;
        do_frame(2'b01, 2'b00);
        check("skip_next", 32'(pattern_sel), 3);
        do_frame(2'b10, 2'b00);
        check("skip_prev", 32'(pattern_sel), 0);
        skip_mask = 4'b1110;
        do_frame(2'b01, 2'b00);
        check("skip_all_sel", 32'(pattern_sel), 0);
        check("skip_all_sw", 32'(switched), 0);
        // current pattern masked keeps displaying until a switch event
        skip_mask = 4'b0001;
        frames(3);
        check("mask_cur", 32'(pattern_sel), 0);
        do_frame(2'b01, 2'b00);
        check("mask_cur_next", 32'(pattern_sel), 1);

        // randomized frames
        for (int i = 0; i < 400; i++) begin
            logic [1:0] mid, erq;
            hold      = ($urandom_range(0, 3) != 0);
            paused    = ($urandom_range(0, 4) == 0);
            skip_mask = N'($urandom);
            mid       = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00;
            erq       = ($urandom_range(0, 5) == 0) ? 2'($urandom) : 2'b00;
            do_frame(mid, erq);
        end

        // async reset with pattern 2 active
        paused = 1'b0; hold = 1'b1; skip_mask = '0;
        for (int i = 0; i < N && m_sel != 2; i++) do_frame(2'b01, 2'b00);
        check("pre_rst_sel", 32'(pattern_sel), 2);
        @(posedge clk); #1;
        vsync = 1'b0; next_req = 1'b1;
        @(posedge clk); #1;
        next_req = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("arst_sel", 32'(pattern_sel), 0);
        check("arst_fc", 32'(frame_count), 0);
        check("arst_sw", 32'(switched), 0);
        check("arst_en", 32'(pattern_en), 1);
        check("arst_rgb", 32'(rgb), 32'(pattern_rgb[RW-1:0]));
        vsync = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("post_rst_tick", 32'(frame_tick), 0);
            check("post_rst_sel", 32'(pattern_sel), 0);
            check("post_rst_sw", 32'(switched), 0);
        end
        // the pending request from before reset must be gone
        frames(2);
        check("post_rst_nopend", 32'(pattern_sel), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
